piezo_alert_sched: RTL and testbench
====================================

Name: piezo_alert_sched

Overview:
Priority scheduler that shares the single piezo transducer between three alert requesters: over-speed, battery-low and moving. It arbitrates the requests and sequences beep bursts inside a fixed repeat period. It gates an internal square-wave tone onto the differential piezo outputs. It sits between the segway status logic and the piezo pins, and replaces the ad-hoc gating of tone and period windows.

Parameters:
TONE_HALF, 5000, clk cycles per tone half-period (5 kHz at 50 MHz).
BEEP_CYC, 5_000_000, clk cycles of tone per beep.
GAP_CYC, 5_000_000, clk cycles of silence between beeps within a burst.
PERIOD_CYC, 100_000_000, clk cycles per pattern period. Constraint: PERIOD_CYC >= 3*(BEEP_CYC+GAP_CYC).
CNT_W, 27, width of the period, beep and tone counters. Must hold PERIOD_CYC-1.

Ports:
clk  in  1  system clock; one clock, all logic on posedge clk
rst  in  1  reset; synchronous, active-high
ovr_spd  in  1  over-speed request, level (class 3, highest priority)
batt_low  in  1  battery-low request, level (class 2)
moving  in  1  moving/steer-enabled request, level (class 1, lowest)
audio_o  out  1  piezo drive, positive
audio_o_n  out  1  piezo drive, negative
active_cls  out  2  class being played: 0 none, 1 moving, 2 batt_low, 3 ovr_spd
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. While rst=1, at the next edge: state=IDLE, all counters=0, audio_o=0, audio_o_n=0, active_cls=0, busy=0. Reset asserted mid-burst aborts the burst immediately.
- Beeps per period by class: class 3 plays 3, class 2 plays 2, class 1 plays 1.
- Arbitration: the highest asserted request wins. Arbitration happens only in IDLE and at the period wrap (period counter = PERIOD_CYC-1).
- State IDLE: outputs silent. If any request is high in cycle N, the block enters BEEP in cycle N+1 with active_cls set, busy=1, period counter=0 and beep index=0.
- State BEEP: lasts BEEP_CYC cycles.
  - The tone counter restarts at every beep start. audio_o=1 for the first TONE_HALF cycles, then toggles every TONE_HALF cycles. audio_o_n = ~audio_o.
  - At the end of the beep, if beeps played < class count, go to GAP. Otherwise go to HOLD.
- State GAP: lasts GAP_CYC cycles, audio_o=audio_o_n=0, then returns to BEEP.
- State HOLD: audio_o=audio_o_n=0 until the period counter reaches PERIOD_CYC-1.
- Period wrap: from any state at period counter = PERIOD_CYC-1, re-arbitrate.
  - Request present: next cycle is BEEP of the new winner, period counter=0.
  - No request: next cycle is IDLE, active_cls=0, busy=0.
- Request deasserting mid-period: the current period's pattern completes unchanged.
- Preemption: if ovr_spd=1 while busy=1 and active_cls != 3, the next cycle is BEEP with active_cls=3. Period counter, beep index and tone counter all restart.
  - A batt_low request never preempts a moving pattern; it waits for the period wrap.
- Simultaneous requests: priority ovr_spd > batt_low > moving.
- When the period wrap and the preemption condition coincide, the wrap rule applies; the result is the same winner.
- Silent in IDLE, GAP and HOLD: both outputs low, never both high.

Optional Feature:
Macro PIEZO_MUTE_EN.
- Defined: adds input port mute (1 bit). While mute=1, the moving request is treated as 0 at arbitration. A class-1 pattern already in progress is cut to silent HOLD on the next cycle, with the period still timing out. Classes 2 and 3 are never muted.
- Undefined: no mute port; behaviour is identical to mute=0.

Test Plan:
All tests use TONE_HALF=2, BEEP_CYC=8, GAP_CYC=4, PERIOD_CYC=64.
1. Reset: hold rst=1 during a ovr_spd burst -> next edge audio_o=0, audio_o_n=0, active_cls=0, busy=0. After rst=0 with no requests, outputs stay 0.
2. moving=1 held from cycle 0 -> cycles 1-8 audio_o=1,1,0,0,1,1,0,0 with audio_o_n inverted. Cycles 9-64 silent. Next beep at cycle 65. active_cls=1.
3. ovr_spd=1 held -> beeps at period offsets 0-7, 12-19 and 24-31, silent 32-63, pattern repeats every 64 cycles. active_cls=3.
4. batt_low=1, then ovr_spd=1 at period offset 20 -> at offset 21 active_cls=3, audio_o=1, period counter=0, three-beep pattern follows.
5. batt_low=1, dropped at offset 10 -> second beep still at offsets 12-19. At the wrap with no request: IDLE, busy=0, active_cls=0.
6. PIEZO_MUTE_EN defined, moving=1, mute=1 -> no tone, busy=0. Asserting batt_low=1 with mute=1 -> two-beep pattern plays normally.

Source files
------------

// File: rtl/piezo_alert_sched.sv
// Piezo alert scheduler: arbitrates three alert classes and plays their beep bursts
// within a fixed repeat period. Optional mute input via `define PIEZO_MUTE_EN.
module piezo_alert_sched #(
    parameter int TONE_HALF  = 5000,
    parameter int BEEP_CYC   = 5_000_000,
    parameter int GAP_CYC    = 5_000_000,
    parameter int PERIOD_CYC = 100_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ovr_spd,
    input  logic       batt_low,
    input  logic       moving,
`ifdef PIEZO_MUTE_EN
    input  logic       mute,
`endif
    output logic       audio_o,
    output logic       audio_o_n,
    output logic [1:0] active_cls,
    output logic       busy
);

    // state | meaning
    // IDLE  | no pattern, outputs silent
    // BEEP  | tone gated onto the piezo for BEEP_CYC cycles
    // GAP   | silence between beeps of one burst
    // HOLD  | burst done (or muted), silent until the period wraps
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEEP = 2'd1,
        S_GAP  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST   = CNT_W'(BEEP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TONE_LAST   = CNT_W'(TONE_HALF - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] tone_q, tone_d;
    logic             lvl_q, lvl_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       cls_q, cls_d;
    logic             audio_q, audio_d;
    logic             audio_n_q, audio_n_d;
    logic             busy_q, busy_d;

    logic             mute_eff;
    logic [1:0]       win;
    logic [1:0]       n_beeps;
    logic             start;

`ifdef PIEZO_MUTE_EN
    assign mute_eff = mute;
`else
    assign mute_eff = 1'b0;
`endif

    always_comb begin
        win = 2'd0;
        if (ovr_spd)                    win = 2'd3;
        else if (batt_low)              win = 2'd2;
        else if (moving && !mute_eff)   win = 2'd1;
    end

    // Class number doubles as the number of beeps per period.
    assign n_beeps = cls_q;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        lvl_d   = lvl_q;
        idx_d   = idx_q;
        cls_d   = cls_q;
        start   = 1'b0;

        if (state_q == S_IDLE) begin
            start = (win != 2'd0);
        end else if (pcnt_q == PERIOD_LAST) begin
            if (win != 2'd0) begin
                start = 1'b1;
            end else begin
                state_d = S_IDLE;
                pcnt_d  = '0;
                phase_d = '0;
                tone_d  = '0;
                lvl_d   = 1'b0;
                idx_d   = 2'd0;
                cls_d   = 2'd0;
            end
        end else if (ovr_spd && cls_q != 2'd3) begin
            start = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
            if (mute_eff && cls_q == 2'd1 && state_q != S_HOLD) begin
                state_d = S_HOLD;
            end else begin
                case (state_q)
                    S_BEEP: begin
                        if (tone_q == '0) begin
                            tone_d = TONE_LAST;
                            lvl_d  = ~lvl_q;
                        end else begin
                            tone_d = tone_q - 1'b1;
                        end
                        if (phase_q == '0) begin
                            if ((idx_q + 2'd1) < n_beeps) begin
                                state_d = S_GAP;
                                phase_d = GAP_LAST;
                                idx_d   = idx_q + 2'd1;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            phase_d = phase_q - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (phase_q == '0) begin
                            state_d = S_BEEP;
                            phase_d = BEEP_LAST;
                            tone_d  = TONE_LAST;
                            lvl_d   = 1'b1;
                        end else begin
                            phase_d = phase_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (start) begin
            state_d = S_BEEP;
            cls_d   = win;
            pcnt_d  = '0;
            phase_d = BEEP_LAST;
            tone_d  = TONE_LAST;
            lvl_d   = 1'b1;
            idx_d   = 2'd0;
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        audio_d   = (state_d == S_BEEP) &&  lvl_d;
        audio_n_d = (state_d == S_BEEP) && !lvl_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            phase_q   <= '0;
            tone_q    <= '0;
            lvl_q     <= 1'b0;
            idx_q     <= 2'd0;
            cls_q     <= 2'd0;
            audio_q   <= 1'b0;
            audio_n_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            phase_q   <= phase_d;
            tone_q    <= tone_d;
            lvl_q     <= lvl_d;
            idx_q     <= idx_d;
            cls_q     <= cls_d;
            audio_q   <= audio_d;
            audio_n_q <= audio_n_d;
            busy_q    <= busy_d;
        end
    end

    assign audio_o    = audio_q;
    assign audio_o_n  = audio_n_q;
    assign active_cls = cls_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Self-checking bench for piezo_alert_sched: a period-offset model predicts each cycle's
// outputs, pushes them to a scoreboard queue and they are compared after the clock edge.
module tb_piezo_alert_sched;

    localparam int TH = 2;
    localparam int BC = 8;
    localparam int GC = 4;
    localparam int PC = 64;

    typedef struct packed {
        logic       a;
        logic       an;
        logic [1:0] c;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ovr_spd = 1'b0, batt_low = 1'b0, moving = 1'b0, mute = 1'b0;
    logic audio_o, audio_o_n, busy;
    logic [1:0] active_cls;

    int n_chk = 0;
    int n_fail = 0;

    exp_t sb_q[$];

    // model state: class playing (0 = idle), period offset, muted-cut flag
    int m_cls = 0;
    int m_off = 0;
    bit m_cut = 1'b0;

    piezo_alert_sched #(
        .TONE_HALF(TH), .BEEP_CYC(BC), .GAP_CYC(GC), .PERIOD_CYC(PC), .CNT_W(27)
    ) dut (
        .clk(clk), .rst(rst), .ovr_spd(ovr_spd), .batt_low(batt_low), .moving(moving),
`ifdef PIEZO_MUTE_EN
        .mute(mute),
`endif
        .audio_o(audio_o), .audio_o_n(audio_o_n), .active_cls(active_cls), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t (cls=%0d off=%0d)",
                     tag, obs, exp, $time, m_cls, m_off);
        end
    endtask

    function automatic bit mute_eff();
`ifdef PIEZO_MUTE_EN
        return mute;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int winner();
        if (ovr_spd) return 3;
        if (batt_low) return 2;
        if (moving && !mute_eff()) return 1;
        return 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int s;
        e = '0;
        if (m_cls != 0) begin
            e.b = 1'b1;
            e.c = 2'(m_cls);
            if (!m_cut) begin
                for (int k = 0; k < m_cls; k++) begin
                    s = k * (BC + GC);
                    if (m_off >= s && m_off < s + BC) begin
                        e.a  = (((m_off - s) / TH) % 2) == 0;
                        e.an = !e.a;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic model_step();
        int w;
        w = winner();
        if (rst) begin
            m_cls = 0; m_off = 0; m_cut = 1'b0;
        end else if (m_cls == 0) begin
            if (w != 0) begin m_cls = w; m_off = 0; m_cut = 1'b0; end
        end else if (m_off == PC - 1) begin
            m_cls = w; m_off = 0; m_cut = 1'b0;
        end else if (ovr_spd && m_cls != 3) begin
            m_cls = 3; m_off = 0; m_cut = 1'b0;
        end else begin
            m_off++;
            if (mute_eff() && m_cls == 1) m_cut = 1'b1;
        end
    endtask

    task automatic step();
        exp_t e;
        model_step();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("audio_o",    {3'b0, audio_o},    {3'b0, e.a});
        chk("audio_o_n",  {3'b0, audio_o_n},  {3'b0, e.an});
        chk("active_cls", {2'b0, active_cls}, {2'b0, e.c});
        chk("busy",       {3'b0, busy},       {3'b0, e.b});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_model(input int cls, input int off);
        int guard;
        guard = 0;
        while (!(m_cls == cls && m_off == off) && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) chk("wait_timeout", 4'd1, 4'd0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_cls != 0 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) chk("idle_timeout", 4'd1, 4'd0);
        steps(2);
    endtask

    initial begin
        steps(2);
        rst = 1'b0;
        steps(3);

        // reset mid ovr_spd burst
        ovr_spd = 1'b1;
        steps(5);
        rst = 1'b1;
        step();
        ovr_spd = 1'b0;
        step();
        rst = 1'b0;
        steps(4);

        // single-beep moving pattern across two periods
        moving = 1'b1;
        steps(140);
        moving = 1'b0;
        wait_idle();

        // three-beep over-speed pattern
        ovr_spd = 1'b1;
        steps(140);
        ovr_spd = 1'b0;
        wait_idle();

        // over-speed preempts battery-low at offset 20
        batt_low = 1'b1;
        wait_model(2, 20);
        ovr_spd = 1'b1;
        step();
        batt_low = 1'b0;
        steps(40);
        ovr_spd = 1'b0;
        wait_idle();

        // battery-low dropped mid-period completes its burst, then idles
        batt_low = 1'b1;
        wait_model(2, 10);
        batt_low = 1'b0;
        wait_idle();

        // battery-low waits behind moving; over-speed preempts moving
        moving = 1'b1;
        steps(20);
        batt_low = 1'b1;
        steps(60);
        ovr_spd = 1'b1;
        steps(10);
        moving = 1'b0; batt_low = 1'b0; ovr_spd = 1'b0;
        wait_idle();

`ifdef PIEZO_MUTE_EN
        mute = 1'b1; moving = 1'b1;
        steps(40);
        batt_low = 1'b1;
        steps(70);
        batt_low = 1'b0;
        mute = 1'b0;
        steps(20);
        mute = 1'b1;
        steps(60);
        moving = 1'b0; mute = 1'b0;
        wait_idle();
`endif

        // random request mix
        for (int i = 0; i < 600; i++) begin
            if (i % 7 == 0) begin
                ovr_spd  = ($urandom_range(0, 5) == 0);
                batt_low = ($urandom_range(0, 2) == 0);
                moving   = ($urandom_range(0, 1) == 0);
                mute     = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0; ovr_spd = 1'b0; batt_low = 1'b0; moving = 1'b0; mute = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
